led_event_stretcher: RTL
========================

// Module: led_event_stretcher
// PURPOSE
//  Output-side counterpart of the button input path. The button path turns slow human input into clean
//  single-cycle pulses; this block turns single-cycle event pulses into human-visible LED flashes.
//  Each accepted event produces one LED burst of fixed length, followed by a dark gap.
//  Events arriving while a burst is in progress are queued in a saturating counter and replayed in order.
//  Sits between core logic (UART rx/tx strobes, FIFO errors, button edges) and board LEDs.
// PARAMETERS
//  ON_TICKS   5_000_000  clk cycles LED is lit per event (>=1)
//  GAP_TICKS  5_000_000  clk cycles LED is dark between consecutive bursts (>=1)
//  PEND_W     4          width of pending-event counter; max queued = 2**PEND_W-1
//  PWM_PERIOD 16         PWM period in clk cycles (used only with LED_STRETCH_PWM_EN)
//  PWM_DUTY   8          lit cycles per PWM period, 0..PWM_PERIOD (used only with LED_STRETCH_PWM_EN)
// PORTS
//  clk       in   1       system clock, rising edge
//  reset_n   in   1       asynchronous active-low reset
//  event_p   in   1       single-cycle event strobe, synchronous to clk
//  clear     in   1       synchronous flush of queued events
//  led       out  1       LED drive, active high, registered
//  busy      out  1       high while in ON or GAP state
//  pending   out  PEND_W  number of queued, not-yet-started events
//  overflow  out  1       one-cycle pulse: an event was dropped because the queue was full
// BEHAVIOUR
//  Reset: state=IDLE; led, busy, pending, overflow, tick counter all 0. Async assert; release is synchronous to clk.
//  FSM
//   IDLE -> ON   on start_req; next state = IDLE otherwise
//   ON   -> GAP  when tick counter reaches 0; counter loads ON_TICKS-1 on entry
//   GAP  -> ON   when counter reaches 0 and start_req; counter loads GAP_TICKS-1 on entry
//   GAP  -> IDLE when counter reaches 0 and no start_req
//  Signal definitions
//   start_req = (pending!=0) | (event_p & ~clear)
//   A start consumes one queued event if pending!=0, otherwise it consumes the incoming event_p.
//  Pending update (per cycle, clear has priority)
//   clear: pending<=0; a same-cycle event_p is discarded; a burst in progress completes normally.
//   Otherwise, incoming event and consume in the same cycle: net change 0.
//   Incoming event not consumed: pending+1, saturating at 2**PEND_W-1.
//   Saturated: overflow<=1 for one cycle; the event is dropped.
//   Consume without incoming event: pending-1.
//  Latency
//   event_p sampled in cycle N while IDLE -> led=1 and busy=1 from cycle N+1.
//   led stays high exactly ON_TICKS cycles; gap is exactly GAP_TICKS cycles.
//  busy=1 throughout ON and GAP; busy=0 in IDLE.
//  Counter: width $clog2(max(ON_TICKS,GAP_TICKS)+1); down-counts; never wraps.
//  Reset asserted mid-burst: led drops to 0 immediately (async); queued events are lost.
// CONFIGURATION
//  LED_STRETCH_PWM_EN defined
//   Free-running pwm_cnt counts 0..PWM_PERIOD-1 and is reset to 0 on every ON entry.
//   led = (state==ON) & (pwm_cnt < PWM_DUTY), registered.
//   PWM_DUTY=0 keeps the LED dark; PWM_DUTY=PWM_PERIOD keeps it fully lit.
//  LED_STRETCH_PWM_EN undefined
//   led = (state==ON); PWM_PERIOD and PWM_DUTY are ignored; no PWM logic is synthesised.
// STRUCTURE
//  Package led_stretch_pkg
//   State encodings ST_IDLE=2'd0, ST_ON=2'd1, ST_GAP=2'd2.
//   Default tick constants for a 100 MHz clk (50 ms ON, 50 ms GAP).
//  Sub-module tick_counter
//   Parameterised down-counter with load, load value and done output.
//   Instantiated once; shared between ON and GAP.
// TESTING (ON_TICKS=4, GAP_TICKS=2, PEND_W=2 unless stated)
//  1 reset_n=0 -> all outputs 0. Release, idle 20 cycles -> led=0, busy=0.
//  2 event_p at cycle 10 -> led=1 cycles 11-14, led=0 cycles 15-16, busy=1 cycles 11-16, pending stays 0.
//  3 event_p at cycles 10,11,12 -> pending 1 then 2, decrements at cycles 17 and 23.
//    Bursts at 11-14, 17-20, 23-26; busy falls at cycle 29.
//  4 Five event_p at cycles 10-14 -> pending saturates at 3; overflow=1 at cycle 15 only.
//    Exactly 4 bursts are produced.
//  5 Three event_p at cycles 10-12, clear at 13 (same cycle as an event_p) -> pending=0 at 14.
//    First burst completes; busy=0 from cycle 17.
//    Separately: reset_n low at cycle 12 -> led=0 at once.
//  6 With LED_STRETCH_PWM_EN, ON_TICKS=32, PWM_PERIOD=8, PWM_DUTY=2 -> led high 2 of every 8 cycles, 8 high cycles total.
//    Repeat with PWM_DUTY=0 -> led never high while busy=1.

Source files
------------

// File: rtl/led_stretch_pkg.sv
// Shared types and constants for the LED event stretcher.
// State encoding, default 100 MHz tick constants, and a small helper for sizing.
package led_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ        = 100_000_000;
  // 50 ms lit and 50 ms dark at 100 MHz
  localparam int unsigned DEF_ON_TICKS  = CLK_HZ / 20;
  localparam int unsigned DEF_GAP_TICKS = CLK_HZ / 20;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_event_stretcher_tick_counter.sv
// Down-counter shared by the ON and GAP phases.
// Loads a value, counts down to zero and holds there; done_o is high at zero.
module tick_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; otherwise decrement, saturating at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/led_event_stretcher.sv
// LED event stretcher: turns single-cycle event strobes into visible LED bursts
// separated by dark gaps, queueing events that arrive during a burst.
// Optional feature macro: LED_STRETCH_PWM_EN (dims the lit phase with a PWM).
module led_event_stretcher
  import led_stretch_pkg::*;
#(
  parameter int unsigned ON_TICKS   = DEF_ON_TICKS,
  parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS,
  parameter int unsigned PEND_W     = 4,
  parameter int unsigned PWM_PERIOD = 16,
  parameter int unsigned PWM_DUTY   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              event_p,
  input  logic              clear,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned       CNT_W    = $clog2(max_u(ON_TICKS, GAP_TICKS) + 1);
  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              led_q, led_d;
  logic              busy_q;
  logic              start_req, start, take_q, ev_left;
  logic              tick_done, cnt_load;
  logic [CNT_W-1:0]  cnt_val;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  tick_counter #(
    .WIDTH(CNT_W)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .done_o    (tick_done)
  );

  // Next state, counter loads and pending-queue bookkeeping
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = ON_LOAD;
    start_req = (pend_q != '0) | (event_p & ~clear);
    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d  = ST_ON;
          start    = 1'b1;
          cnt_load = 1'b1;
        end
      end
      ST_ON: begin
        if (tick_done) begin
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tick_done) begin
          if (start_req) begin
            state_d  = ST_ON;
            start    = 1'b1;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A start drains the queue first; the live strobe is used only when the queue is empty
    take_q  = start & (pend_q != '0);
    ev_left = event_p & ~(start & (pend_q == '0));

    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (clear) begin
      pend_d = '0;
    end else if (ev_left & ~take_q) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (~ev_left & take_q) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

`ifdef LED_STRETCH_PWM_EN
  localparam int unsigned PWM_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  logic [PWM_W-1:0] pwm_q, pwm_d;

  // Free-running PWM phase, restarted on every burst so each burst opens lit
  always_comb begin
    if (start || (32'(pwm_q) >= PWM_PERIOD - 1)) begin
      pwm_d = '0;
    end else begin
      pwm_d = pwm_q + PWM_W'(1);
    end
  end

  // PWM phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign led_d = (state_d == ST_ON) & (32'(pwm_d) < PWM_DUTY);
`else
  assign led_d = (state_d == ST_ON);
`endif

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule
